// File: rtl/scytale_pkg.sv
// Shared definitions for the scytale encryption/decryption blocks: token, default sizes,
// FSM states and index-width helper. Optional padding is enabled with SCYTALE_ENC_PAD_EN.
package scytale_pkg;

    localparam int         DEF_D_WIDTH       = 8;
    localparam int         DEF_KEY_WIDTH     = 8;
    localparam int         DEF_MAX_NOF_CHARS = 50;
    localparam logic [7:0] START_TOKEN       = 8'hFA;
    localparam logic [7:0] DEF_PAD_CHAR      = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DONE
    } scytale_state_e;

    // Width able to hold every value 0..depth, so a full buffer count still fits.
    function automatic int idx_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/scytale_encryption_if.sv
// Byte-stream bus of the scytale encryption block: plaintext/keys in, ciphertext out.
interface scytale_encryption_if #(
    parameter int D_WIDTH   = 8,
    parameter int KEY_WIDTH = 8
);
    logic [D_WIDTH-1:0]   data_i;
    logic                 valid_i;
    logic [KEY_WIDTH-1:0] key_N;
    logic [KEY_WIDTH-1:0] key_M;
    logic                 busy;
    logic [D_WIDTH-1:0]   data_o;
    logic                 valid_o;

    modport master (
        output data_i, valid_i, key_N, key_M,
        input  busy, data_o, valid_o
    );

    modport slave (
        input  data_i, valid_i, key_N, key_M,
        output busy, data_o, valid_o
    );
endinterface

// File: rtl/scytale_index_gen.sv
// Nested-loop read-index walk of the scytale matrix: for r in 0..M-1, k = r, r+M, ... < L.
// Keys and length are latched on start so later changes on the bus are ignored.
module scytale_index_gen #(
    parameter int IW        = 6,
    parameter int KEY_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [IW-1:0]        len,
    input  logic [KEY_WIDTH-1:0] key_m,
    output logic [IW-1:0]        k,
    output logic                 valid,
    output logic                 last
);

    localparam int SW = ((IW > KEY_WIDTH) ? IW : KEY_WIDTH) + 1;

    logic                 active_q, active_d;
    logic [IW-1:0]        r_q, r_d;
    logic [IW-1:0]        k_q, k_d;
    logic [IW-1:0]        len_q, len_d;
    logic [KEY_WIDTH-1:0] m_q, m_d;
    logic [SW-1:0]        k_next;
    logic [SW-1:0]        r_next;
    logic                 row_end;
    logic                 walk_end;

    always_comb begin
        // NOTE: every variable gets a default first, so no path through this block can infer a latch.
        active_d = active_q;
        r_d      = r_q;
        k_d      = k_q;
        len_d    = len_q;
        m_d      = m_q;

        k_next   = SW'(k_q) + SW'(m_q);
        r_next   = SW'(r_q) + SW'(1);
        row_end  = (k_next >= SW'(len_q));
        walk_end = row_end && ((r_next >= SW'(m_q)) || (r_next >= SW'(len_q)));

        if (start) begin
            active_d = 1'b1;
            r_d      = '0;
            k_d      = '0;
            len_d    = len;
            m_d      = (key_m == '0) ? KEY_WIDTH'(1) : key_m;
        end else if (active_q) begin
            if (walk_end) begin
                active_d = 1'b0;
                r_d      = '0;
                k_d      = '0;
            end else if (row_end) begin
                r_d = IW'(r_next);
                k_d = IW'(r_next);
            end else begin
                k_d = IW'(k_next);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: flops use <= so every register samples the pre-edge values of the others.
        if (rst) begin
            active_q <= 1'b0;
            r_q      <= '0;
            k_q      <= '0;
            len_q    <= '0;
            m_q      <= '0;
        end else begin
            active_q <= active_d;
            r_q      <= r_d;
            k_q      <= k_d;
            len_q    <= len_d;
            m_q      <= m_d;
        end
    end

    assign k     = k_q;
    assign valid = active_q;
    assign last  = active_q && walk_end;

endmodule

// File: rtl/scytale_encryption.sv
// Scytale encryption: buffers a token-terminated plaintext, then streams the ciphertext one
// character per cycle. Define SCYTALE_ENC_PAD_EN to pad short messages to a full key_N x key_M matrix.
module scytale_encryption
    import scytale_pkg::*;
#(
    parameter int                 D_WIDTH                = DEF_D_WIDTH,
    parameter int                 KEY_WIDTH              = DEF_KEY_WIDTH,
    parameter int                 MAX_NOF_CHARS          = DEF_MAX_NOF_CHARS,
    parameter logic [D_WIDTH-1:0] START_ENCRYPTION_TOKEN = D_WIDTH'(START_TOKEN)
`ifdef SCYTALE_ENC_PAD_EN
   ,parameter logic [D_WIDTH-1:0] PAD_CHAR               = D_WIDTH'(DEF_PAD_CHAR)
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    scytale_encryption_if.slave  bus
);

    localparam int            IW    = idx_width(MAX_NOF_CHARS);
    localparam int            PW    = 2 * KEY_WIDTH;
    localparam logic [IW-1:0] MAX_N = IW'(MAX_NOF_CHARS);

    scytale_state_e     state_q, state_d;
    logic [IW-1:0]      n_q, n_d;
    logic               busy_q, busy_d;
    logic               valid_o_q, valid_o_d;
    logic [D_WIDTH-1:0] data_o_q, data_o_d;

    logic [D_WIDTH-1:0] msg_mem [MAX_NOF_CHARS];

    logic               is_token;
    logic               start;
    logic               wr_en;
    logic [IW-1:0]      emit_len;
    logic [IW-1:0]      gen_k;
    logic               gen_valid;
    logic               gen_last;
    logic [D_WIDTH-1:0] rd_char;

`ifdef SCYTALE_ENC_PAD_EN
    logic [KEY_WIDTH-1:0] m_eff;
    logic [PW-1:0]        prod;

    always_comb begin
        m_eff = (bus.key_M == '0) ? KEY_WIDTH'(1) : bus.key_M;
        prod  = PW'(bus.key_N) * PW'(m_eff);
        // key_N == 0 describes no matrix at all; fall back to the plain message length.
        if (prod == '0) begin
            emit_len = n_q;
        end else if (prod < PW'(MAX_NOF_CHARS)) begin
            emit_len = IW'(prod);
        end else begin
            emit_len = MAX_N;
        end
    end

    always_comb begin
        rd_char = PAD_CHAR;
        if (gen_k < n_q) begin
            rd_char = msg_mem[gen_k];
        end
    end
`else
    assign emit_len = n_q;

    always_comb begin
        rd_char = '0;
        if (gen_k < n_q) begin
            rd_char = msg_mem[gen_k];
        end
    end
`endif

    scytale_index_gen #(
        .IW        (IW),
        .KEY_WIDTH (KEY_WIDTH)
    ) u_index_gen (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .len   (emit_len),
        .key_m (bus.key_M),
        .k     (gen_k),
        .valid (gen_valid),
        .last  (gen_last)
    );

    always_comb begin
        is_token = (bus.data_i == START_ENCRYPTION_TOKEN);
        start    = (state_q == IDLE) && bus.valid_i && is_token && (n_q != '0);
        wr_en    = (state_q == IDLE) && bus.valid_i && !is_token && (n_q < MAX_N);

        state_d   = state_q;
        n_d       = n_q;
        busy_d    = busy_q;
        valid_o_d = 1'b0;
        data_o_d  = '0;

        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    n_d = n_q + 1'b1;
                end
                if (start) begin
                    state_d = EMIT;
                    busy_d  = 1'b1;
                end
            end
            EMIT: begin
                if (gen_valid) begin
                    valid_o_d = 1'b1;
                    data_o_d  = rd_char;
                end
                if (gen_last || !gen_valid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                n_d     = '0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                n_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            busy_q    <= 1'b0;
            valid_o_q <= 1'b0;
            data_o_q  <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            busy_q    <= busy_d;
            valid_o_q <= valid_o_d;
            data_o_q  <= data_o_d;
        end
    end

    // NOTE: the message buffer has no reset; n_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            msg_mem[n_q] <= bus.data_i;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.valid_o = valid_o_q;
    assign bus.data_o  = data_o_q;

endmodule

// File: tb/tb_scytale_encryption.sv
// Directed bench for scytale_encryption: ordering, latency, reset abort, overflow and busy-input
// rejection; the padding case runs only when SCYTALE_ENC_PAD_EN is defined.
module tb_scytale_encryption;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] ct_q[$];

    always #5 clk = ~clk;

    scytale_encryption_if #(.D_WIDTH(8), .KEY_WIDTH(8)) bus ();

    scytale_encryption dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called on a falling edge; the character is sampled on the next rising edge.
    task automatic send_char(input logic [7:0] c);
        bus.data_i  = c;
        bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.data_i  = 8'h00;
    endtask

    task automatic run_msg(input string tag, input string msg, input int kn, input int km,
                           input string exp, input bit inject);
        bus.key_N = 8'(kn);
        bus.key_M = 8'(km);
        for (int i = 0; i < msg.len(); i++) send_char(msg[i]);
        send_char(8'hFA);
        check({tag, "_lat_busy"},  32'(bus.busy),    32'd1);
        check({tag, "_lat_valid"}, 32'(bus.valid_o), 32'd0);
        ct_q.delete();
        for (int j = 0; j < exp.len(); j++) begin
            if (inject) begin
                bus.valid_i = (j == 1 || j == 2);
                bus.data_i  = (j == 1) ? 8'h51 : ((j == 2) ? 8'hFA : 8'h00);
                if (j == 3) bus.key_M = 8'd5;
            end
            @(negedge clk);
            check($sformatf("%s_valid%0d", tag, j), 32'(bus.valid_o), 32'd1);
            check($sformatf("%s_data%0d",  tag, j), 32'(bus.data_o),  32'(exp[j]));
            check($sformatf("%s_busy%0d",  tag, j), 32'(bus.busy),    32'd1);
            ct_q.push_back(bus.data_o);
        end
        bus.valid_i = 1'b0;
        bus.data_i  = 8'h00;
        bus.key_M   = 8'(km);
        @(negedge clk);
        check({tag, "_end_valid"}, 32'(bus.valid_o), 32'd0);
        check({tag, "_end_data"},  32'(bus.data_o),  32'd0);
        check({tag, "_end_busy"},  32'(bus.busy),    32'd0);
    endtask

    initial begin
        string plain;
        bus.data_i  = 8'h00;
        bus.valid_i = 1'b0;
        bus.key_N   = 8'd0;
        bus.key_M   = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(bus.busy),    32'd0);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_data",  32'(bus.data_o),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic 3x2 matrix, then invert the captured ciphertext by row/column transposition.
        run_msg("m3x2", "ABCDEF", 3, 2, "ACEBDF", 1'b0);
        plain = "ABCDEF";
        for (int i = 0; i < 6; i++)
            check($sformatf("loop%0d", i), 32'(ct_q[(i % 2) * 3 + i / 2]), 32'(plain[i]));

        // Reset in the second output cycle aborts emission.
        bus.key_N = 8'd2;
        bus.key_M = 8'd2;
        for (int i = 0; i < 4; i++) send_char(8'h57 + 8'(i));
        send_char(8'hFA);
        @(negedge clk);
        check("abort_first", 32'(bus.data_o), 32'h57);
        @(negedge clk);
        check("abort_second", 32'(bus.data_o), 32'h59);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",  32'(bus.busy),    32'd0);
        check("abort_valid", 32'(bus.valid_o), 32'd0);
        check("abort_data",  32'(bus.data_o),  32'd0);
        @(negedge clk);
        check("abort_quiet", 32'(bus.valid_o), 32'd0);
        run_msg("after_rst", "ABCD", 2, 2, "ACBD", 1'b0);

        // Token with empty buffer does nothing.
        send_char(8'hFA);
        check("empty_busy",  32'(bus.busy),    32'd0);
        check("empty_valid", 32'(bus.valid_o), 32'd0);
        @(negedge clk);
        check("empty_valid2", 32'(bus.valid_o), 32'd0);

        // key_M == 0 acts as 1: plaintext order.
        run_msg("m0", "HELLO", 5, 0, "HELLO", 1'b0);

        // Overflow: 51 characters into a 50-deep buffer, 5x10 key.
        bus.key_N = 8'd5;
        bus.key_M = 8'd10;
        for (int i = 0; i < 51; i++) send_char(8'(i + 1));
        send_char(8'hFA);
        check("ovf_lat_valid", 32'(bus.valid_o), 32'd0);
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            check($sformatf("ovf_valid%0d", j), 32'(bus.valid_o), 32'd1);
            check($sformatf("ovf_data%0d", j), 32'(bus.data_o), 32'((j / 5) + 10 * (j % 5) + 1));
        end
        @(negedge clk);
        check("ovf_end_valid", 32'(bus.valid_o), 32'd0);
        check("ovf_end_busy",  32'(bus.busy),    32'd0);

        // Inputs and key changes while busy are ignored; next message unaffected.
        run_msg("inject", "ABCDEF", 3, 2, "ACEBDF", 1'b1);
        run_msg("post_inject", "WXYZ", 2, 2, "WYXZ", 1'b0);

`ifdef SCYTALE_ENC_PAD_EN
        run_msg("pad", "ABCD", 3, 2, "AC BD ", 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
